// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial packed-BCD subtractor.
package bcd_serial_subtractor_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] dig);
    return dig <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Request/result bundle of the serial BCD subtractor; master drives operands.
interface bcd_serial_subtractor_if
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);
  logic                      start;
  logic [DIGIT_W*DIGITS-1:0] a;
  logic [DIGIT_W*DIGITS-1:0] b;
  logic                      bi;
  logic                      ready;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] d;
  logic                      bo;
  logic                      err;

  modport master (
    output start, a, b, bi,
    input  ready, busy, done, d, bo, err
  );

  modport slave (
    input  start, a, b, bi,
    output ready, busy, done, d, bo, err
  );
endinterface

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// One ten's-complement BCD digit step: a + (9 - b) + ci, folded back into 0..9.
module bcd_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] d,
  output logic               co
);
  logic [DIGIT_W:0] t;

  always_comb begin
    t  = {1'b0, a} + ({1'b0, BCD_MAX} - {1'b0, b}) + {{DIGIT_W{1'b0}}, ci};
    co = t > {1'b0, BCD_MAX};
    d  = co ? DIGIT_W'(t - 5'd10) : t[DIGIT_W-1:0];
  end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// Packed-BCD subtractor D = A - B - Bi, one digit per clock, LSD first.
module bcd_serial_subtractor
  import bcd_serial_subtractor_pkg::*;
#(
  parameter int unsigned DIGITS = 4
)(
  input  logic clk,
  input  logic rst_n,
  bcd_serial_subtractor_if.slave io
);
  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, d_q;
  logic [IDX_W-1:0]   idx_q;
  logic               c_q, bo_q, err_q;
  logic               bad, accept, last;
  logic [DIGIT_W-1:0] dig;
  logic               c_out;

  always_comb begin
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(io.a[i*DIGIT_W +: DIGIT_W]) ||
          !is_bcd_digit(io.b[i*DIGIT_W +: DIGIT_W]))
        bad = 1'b1;
    end
  end

  assign accept = io.start && (state_q != RUN);
  assign last   = (idx_q == LAST);

  // Operands shift right each RUN cycle so the active digit is always at [3:0].
  bcd_digit_sub u_digit_sub (
    .a  (a_q[DIGIT_W-1:0]),
    .b  (b_q[DIGIT_W-1:0]),
    .ci (c_q),
    .d  (dig),
    .co (c_out)
  );

  always_comb begin
    state_d  = state_q;
    io.ready = 1'b0;
    io.busy  = 1'b0;
    io.done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        io.ready = 1'b1;
        if (io.start) state_d = bad ? FIN : RUN;
      end
      RUN: begin
        io.busy = 1'b1;
        if (last) state_d = FIN;
      end
      FIN: begin
        io.ready = 1'b1;
        io.done  = 1'b1;
        state_d  = io.start ? (bad ? FIN : RUN) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      d_q   <= '0;
      idx_q <= '0;
      c_q   <= 1'b0;
      bo_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      a_q   <= io.a;
      b_q   <= io.b;
      d_q   <= '0;
      idx_q <= '0;
      c_q   <= ~io.bi;
      bo_q  <= 1'b0;
      err_q <= bad;
    end else if (state_q == RUN) begin
      a_q                         <= a_q >> DIGIT_W;
      b_q                         <= b_q >> DIGIT_W;
      d_q[idx_q*DIGIT_W +: DIGIT_W] <= dig;
      c_q                         <= c_out;
      idx_q                       <= idx_q + 1'b1;
      if (last) bo_q <= ~c_out;
    end
  end

  assign io.d   = d_q;
  assign io.bo  = bo_q;
  assign io.err = err_q;
endmodule
